// File: rtl/jtcop_gfxrom_arb_pkg.sv
// jtcop_gfxrom_arb_pkg: shared types, constants and round-robin helper for the tile-ROM arbiter
package jtcop_gfxrom_arb_pkg;
    localparam int NREQ = 3;
    localparam int IDW  = 2;
    localparam logic [IDW-1:0] BA0 = 2'd0;
    localparam logic [IDW-1:0] BA1 = 2'd1;
    localparam logic [IDW-1:0] BA2 = 2'd2;
    typedef enum logic [1:0] { IDLE, WAIT, GAP } state_t;
    function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] id);
        return id == BA2 ? BA0 : id + BA1;
    endfunction
endpackage

// File: rtl/jtcop_gfxrom_arb_if.sv
// jtcop_gfxrom_arb_if: requester slot buses plus the shared SDRAM read port
interface jtcop_gfxrom_arb_if #(
    parameter int AW = 17,
    parameter int DW = 32
);
    import jtcop_gfxrom_arb_pkg::*;
    logic [NREQ-1:0]    req_cs;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ok;
    logic               sdram_cs;
    logic [AW+IDW-1:0]  sdram_addr;
    logic [DW-1:0]      sdram_data;
    logic               sdram_ok;
    modport slave (
        input  req_cs, req_addr, sdram_data, sdram_ok,
        output req_data, req_ok, sdram_cs, sdram_addr
    );
    modport master (
        output req_cs, req_addr, sdram_data, sdram_ok,
        input  req_data, req_ok, sdram_cs, sdram_addr
    );
endinterface

// File: rtl/jtcop_rr_pick.sv
// jtcop_rr_pick: first set miss bit scanning upward from the slot after i_last, with wrap
module jtcop_rr_pick
    import jtcop_gfxrom_arb_pkg::*;
(
    input  logic [NREQ-1:0] i_miss,
    input  logic [IDW-1:0]  i_last,
    output logic [IDW-1:0]  o_grant,
    output logic            o_any
);
    logic [IDW-1:0] w_s0, w_s1, w_s2;
    always_comb begin
        w_s0    = rr_next(i_last);
        w_s1    = rr_next(w_s0);
        w_s2    = rr_next(w_s1);
        o_grant = i_miss[w_s0] ? w_s0 : i_miss[w_s1] ? w_s1 : w_s2;
        o_any   = |i_miss;
    end
endmodule

// File: rtl/jtcop_gfxrom_arb.sv
// jtcop_gfxrom_arb: shares one SDRAM read slot among three tile-ROM requesters, each with a one-entry cache
module jtcop_gfxrom_arb
    import jtcop_gfxrom_arb_pkg::*;
#(
    parameter int AW = 17,
    parameter int DW = 32
) (
    input logic               clk,
    input logic               rst,
    jtcop_gfxrom_arb_if.slave bus
);
    state_t          r_state, w_state_nx;
    logic [AW-1:0]   r_c_addr [NREQ];
    logic [DW-1:0]   r_c_data [NREQ];
    logic [NREQ-1:0] r_c_valid;
    logic [IDW-1:0]  r_last, r_gid, w_grant;
    logic [AW-1:0]   r_gaddr;
    logic            r_cs;
    logic [NREQ-1:0] w_ok, w_miss;
    logic            w_any, w_take, w_fill;

    genvar n;
    generate
        for (n = 0; n < NREQ; n++) begin : g_req
            assign w_ok[n] = bus.req_cs[n] & r_c_valid[n] & (r_c_addr[n] == bus.req_addr[n*AW +: AW]);
            assign bus.req_data[n*DW +: DW] = r_c_data[n];
        end
    endgenerate

    assign w_miss         = bus.req_cs & ~w_ok;
    assign bus.req_ok     = w_ok;
    assign bus.sdram_cs   = r_cs;
    assign bus.sdram_addr = {r_gid, r_gaddr};

    jtcop_rr_pick u_pick (
        .i_miss  (w_miss),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    always_comb begin
        w_take     = (r_state == IDLE) & w_any;
        w_fill     = (r_state == WAIT) & bus.sdram_ok;
        w_state_nx = w_take ? WAIT : w_fill ? GAP : r_state == GAP ? IDLE : r_state;
    end

    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last    <= BA2;
            r_gid     <= BA0;
            r_gaddr   <= '0;
            r_cs      <= 1'b0;
            r_c_valid <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_c_addr[i] <= '0;
                r_c_data[i] <= '0;
            end
        end else begin
            if (w_take) begin
                r_gid   <= w_grant;
                r_gaddr <= bus.req_addr[w_grant*AW +: AW];
                r_last  <= w_grant;
            end
            r_cs <= w_take | (r_cs & ~w_fill);
            if (w_fill) begin
                r_c_valid[r_gid] <= 1'b1;
                r_c_addr[r_gid]  <= r_gaddr;
                r_c_data[r_gid]  <= bus.sdram_data;
            end
        end
    end
endmodule

// File: tb/tb_jtcop_gfxrom_arb.sv
// tb_jtcop_gfxrom_arb: directed and random stimulus checked against a transaction-level arbiter model
module tb_jtcop_gfxrom_arb;
    import jtcop_gfxrom_arb_pkg::*;
    localparam int AW = 17;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtcop_gfxrom_arb_if #(.AW(AW), .DW(DW)) bus();
    jtcop_gfxrom_arb #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    logic [2:0]    m_valid;
    logic [AW-1:0] m_addr [3];
    logic [DW-1:0] m_data [3];
    int            m_last, m_gid, m_cool, lat;
    bit            m_pend;
    logic [AW-1:0] m_gaddr;
    int            fixed_lat = -1;
    bit            spur_ok = 0;
    logic [DW-1:0] fill_word = '0;
    int            g_log [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_hit(input int n);
        return bus.req_cs[n] && m_valid[n] && m_addr[n] == bus.req_addr[n*AW +: AW];
    endfunction

    task automatic m_reset();
        m_valid = '0;
        for (int i = 0; i < 3; i++) begin
            m_addr[i] = '0;
            m_data[i] = '0;
        end
        m_last = 2;
        m_pend = 0;
        m_cool = 0;
        m_gid = 0;
        m_gaddr = '0;
    endtask

    // One clock: drive the SDRAM response, advance the model at the edge, then compare.
    task automatic step();
        bus.sdram_data = fill_word;
        bus.sdram_ok   = spur_ok && !m_pend;
        if (m_pend) begin
            if (lat == 0) bus.sdram_ok = 1'b1;
            else lat--;
        end
        @(posedge clk);
        if (rst) m_reset();
        else if (m_pend) begin
            if (bus.sdram_ok) begin
                m_data[m_gid]  = bus.sdram_data;
                m_addr[m_gid]  = m_gaddr;
                m_valid[m_gid] = 1'b1;
                m_pend = 0;
                m_cool = 1;
            end
        end else if (m_cool > 0) m_cool--;
        else begin
            for (int k = 1; k <= 3; k++) begin
                int n;
                n = (m_last + k) % 3;
                if (bus.req_cs[n] && !m_hit(n)) begin
                    m_pend  = 1;
                    m_gid   = n;
                    m_gaddr = bus.req_addr[n*AW +: AW];
                    m_last  = n;
                    lat     = fixed_lat >= 0 ? fixed_lat : $urandom_range(0, 5);
                    g_log.push_back(n);
                    break;
                end
            end
        end
        #1;
        chk("sdram_cs", bus.sdram_cs, m_pend);
        if (m_pend) chk("sdram_addr", bus.sdram_addr, {m_gid[1:0], m_gaddr});
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("req_ok%0d", n), bus.req_ok[n], m_hit(n));
            chk($sformatf("req_data%0d", n), bus.req_data[n*DW +: DW], m_data[n]);
        end
    endtask

    task automatic settle();
        int t;
        for (t = 0; t < 40 && (m_pend || m_cool > 0); t++) step();
        chk("settle_timeout", t < 40, 1'b1);
        step();
    endtask

    initial begin
        int t, cnt, nlog;
        int exp_ord [4] = '{0, 1, 2, 0};
        bit changed;
        m_reset();
        bus.req_cs = '0;
        bus.req_addr = '0;
        bus.sdram_ok = 1'b0;
        bus.sdram_data = '0;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();
        chk("rst_cs", bus.sdram_cs, 1'b0);
        chk("rst_addr", bus.sdram_addr, '0);
        chk("rst_ok", bus.req_ok, 3'b000);
        chk("rst_data", bus.req_data, '0);

        fixed_lat = 5;
        fill_word = 32'hCAFEF00D;
        bus.req_cs = 3'b010;
        bus.req_addr[AW +: AW] = 17'h00123;
        step();
        chk("sm_addr", bus.sdram_addr, {2'd1, 17'h00123});
        cnt = 0;
        for (t = 0; t < 20 && !bus.req_ok[1]; t++) begin
            step();
            cnt++;
        end
        chk("sm_latency", cnt, 6);
        chk("sm_ok", bus.req_ok[1], 1'b1);
        chk("sm_data", bus.req_data[DW +: DW], 32'hCAFEF00D);
        fill_word = '0;

        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt += int'(bus.sdram_cs);
        end
        chk("hit_no_cs", cnt, 0);
        bus.req_addr[AW +: AW] = 17'h00124;
        #1;
        chk("chg_ok_drop", bus.req_ok[1], 1'b0);
        step();
        chk("chg_refetch", bus.sdram_addr, {2'd1, 17'h00124});
        settle();

        fixed_lat = -1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        g_log.delete();
        bus.req_addr = {17'h300, 17'h200, 17'h100};
        bus.req_cs = 3'b111;
        changed = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (!changed && m_valid[0]) begin
                bus.req_addr[0 +: AW] = 17'h101;
                changed = 1;
            end
        end
        chk("fair_count", g_log.size(), 4);
        for (int i = 0; i < 4 && i < g_log.size(); i++)
            chk($sformatf("fair_order%0d", i), g_log[i], exp_ord[i]);

        bus.req_cs = 3'b100;
        bus.req_addr[2*AW +: AW] = 17'h10;
        fixed_lat = 4;
        nlog = g_log.size();
        for (t = 0; t < 10 && !m_pend; t++) step();
        chk("mf_grant", bus.sdram_cs, 1'b1);
        step();
        bus.req_addr[2*AW +: AW] = 17'h20;
        for (t = 0; t < 20 && m_pend; t++) step();
        chk("mf_first_ok", bus.req_ok[2], 1'b0);
        for (t = 0; t < 30 && !bus.req_ok[2]; t++) step();
        chk("mf_second_ok", bus.req_ok[2], 1'b1);
        chk("mf_fetches", g_log.size() - nlog, 2);
        settle();

        fixed_lat = 10;
        bus.req_cs = 3'b001;
        bus.req_addr[0 +: AW] = 17'h55;
        for (t = 0; t < 10 && !m_pend; t++) step();
        chk("rw_grant", bus.sdram_cs, 1'b1);
        repeat (2) step();
        rst = 1'b1;
        bus.req_cs = '0;
        step();
        rst = 1'b0;
        step();
        spur_ok = 1;
        fill_word = 32'hDEADBEEF;
        step();
        spur_ok = 0;
        step();
        chk("rw_cs", bus.sdram_cs, 1'b0);
        bus.req_cs = 3'b111;
        #1;
        chk("rw_ok", bus.req_ok, 3'b000);
        step();
        chk("rw_idle_grant", bus.sdram_cs, 1'b1);
        fixed_lat = -1;
        settle();

        for (int i = 0; i < 1500; i++) begin
            for (int n = 0; n < 3; n++) begin
                if ($urandom_range(0, 7) == 0) bus.req_cs[n] = ~bus.req_cs[n];
                if ($urandom_range(0, 5) == 0) bus.req_addr[n*AW +: AW] = AW'($urandom_range(0, 3));
            end
            spur_ok   = $urandom_range(0, 9) == 0;
            fill_word = $urandom;
            rst       = $urandom_range(0, 299) == 0;
            step();
        end
        rst = 1'b0;
        spur_ok = 0;
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
